// File: rtl/uart_pkg.sv
// Shared constants for the UART receive framer: state encodings, default
// frame width and the idle level of the serial line.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam logic RX_IDLE = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx line plus a falling-edge
// detector on the synchronized level.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_d_q;

  // Flops reset to the idle level so leaving reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RX_IDLE}};
      rx_d_q <= RX_IDLE;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_d_q & ~rx_s;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start detect, mid-bit sampling LSB-first, stop check.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 bpsclk,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
  output logic                 parity_err,
`endif
  output logic                 bpssrt,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  localparam int CW = $clog2(DATA_BITS);

  logic                 rx_s;
  logic                 fall;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 fe_q, fe_d;
  logic                 bpssrt_q;
  logic                 par_ok;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

`ifdef UART_RX_PARITY_EN
  logic pbad_q, pbad_d;
  logic pe_q, pe_d;
  assign par_ok     = ~pbad_q;
  assign parity_err = pe_q;
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad_q;
    pe_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: if (fall) state_d = ST_START;
      ST_START: begin
        if (bpsclk) begin
          if (!rx_s) begin
            state_d = ST_DATA;
            cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
            pbad_d  = 1'b0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (bpsclk) begin
          // Line is LSB-first: shifting in at the MSB leaves bit 0 at the bottom.
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bpsclk) begin
          pbad_d  = rx_s ^ (^shreg_q) ^ parity_odd;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bpsclk) begin
          state_d = ST_IDLE;
          if (rx_s) begin
            if (par_ok) begin
              data_d = shreg_q;
              dv_d   = 1'b1;
            end
          end else begin
            fe_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          pe_d = pbad_q;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      fe_q     <= 1'b0;
      bpssrt_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q   <= 1'b0;
      pe_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
      fe_q     <= fe_d;
      // Generator runs continuously from START entry to the stop decision.
      bpssrt_q <= (state_d != ST_IDLE);
`ifdef UART_RX_PARITY_EN
      pbad_q   <= pbad_d;
      pe_q     <= pe_d;
`endif
    end
  end

  assign bpssrt     = bpssrt_q;
  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != ST_IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with a behavioural baud-rate generator
// (434 clk per bit, mid-bit pulse) driving bpsclk from the DUT's bpssrt.
module tb_uart_rx_frame;

  localparam int BIT = 434;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       bpsclk;
  logic       bpssrt;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] state_dbg;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd;
  logic       parity_err;
  int         pe_cnt;
`endif

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  int          gen_cnt = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  int          fe_cnt;
  int          dv_cyc;
  logic        bpssrt_seen;
  logic        busy_seen;

  uart_rx_frame dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .bpsclk     (bpsclk),
`ifdef UART_RX_PARITY_EN
    .parity_odd (parity_odd),
    .parity_err (parity_err),
`endif
    .bpssrt     (bpssrt),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // baud-rate generator model: divider cleared while bpssrt is low
  always @(posedge clk) begin
    if (!bpssrt) gen_cnt <= 0;
    else if (gen_cnt == BIT - 1) gen_cnt <= 0;
    else gen_cnt <= gen_cnt + 1;
  end
  assign bpsclk = bpssrt && (gen_cnt == BIT / 2);

  // monitor
  always @(negedge clk) begin
    if (data_valid) begin
      got_q.push_back(data);
      dv_cyc = cyc;
    end
    if (frame_err) fe_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
    if (bpssrt) bpssrt_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  // driver tasks
  task automatic drive_bit(input logic v);
    @(negedge clk);
    rx = v;
    repeat (BIT - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic use_par,
                            input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (use_par) drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    fe_cnt = 0;
    dv_cyc = -1;
    bpssrt_seen = 1'b0;
    busy_seen = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_cnt = 0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (bpssrt !== 1'b0) begin tests_failed++; $display("FAIL reset_bpssrt: got %b expected 0", bpssrt); end
    tests_run++; if (data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", data); end
    tests_run++; if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_dv: got %b expected 0", data_valid); end
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_fe: got %b expected 0", frame_err); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (state_dbg !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
  endtask

  task automatic test_single_frame();
    int t0;
    clear_mon();
    repeat (10) @(negedge clk);
    exp_q.push_back(8'hA5);
    t0 = cyc + 1;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    tests_run++; if (got_q.size() !== exp_q.size()) begin tests_failed++; $display("FAIL a5_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    else begin
      tests_run++; if (got_q[0] !== exp_q[0]) begin tests_failed++; $display("FAIL a5_data: got %h expected %h", got_q[0], exp_q[0]); end
    end
    // start edge to strobe: 3 clk sync/edge, 218 clk to mid start, 9 bits
    tests_run++; if (dv_cyc - t0 < 4120 || dv_cyc - t0 > 4135) begin tests_failed++; $display("FAIL a5_latency: got %0d expected 4120..4135", dv_cyc - t0); end
    tests_run++; if (fe_cnt !== 0) begin tests_failed++; $display("FAIL a5_fe: got %0d expected 0", fe_cnt); end
    tests_run++; if (bpssrt !== 1'b0) begin tests_failed++; $display("FAIL a5_bpssrt: got %b expected 0", bpssrt); end
    tests_run++; if (data !== 8'hA5) begin tests_failed++; $display("FAIL a5_hold: got %h expected a5", data); end
  endtask

  task automatic test_glitch();
    clear_mon();
    @(negedge clk);
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (500) @(negedge clk);
    tests_run++; if (bpssrt_seen !== 1'b1) begin tests_failed++; $display("FAIL glitch_bpssrt_rise: got %b expected 1", bpssrt_seen); end
    tests_run++; if (bpssrt !== 1'b0) begin tests_failed++; $display("FAIL glitch_bpssrt_drop: got %b expected 0", bpssrt); end
    tests_run++; if (got_q.size() !== 0) begin tests_failed++; $display("FAIL glitch_dv: got %0d expected 0", got_q.size()); end
    tests_run++; if (fe_cnt !== 0) begin tests_failed++; $display("FAIL glitch_fe: got %0d expected 0", fe_cnt); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy: got %b expected 0", busy); end
  endtask

  task automatic test_break();
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    busy_seen = 1'b0;
    repeat (2000) @(negedge clk);
    tests_run++; if (fe_cnt !== 1) begin tests_failed++; $display("FAIL break_fe: got %0d expected 1", fe_cnt); end
    tests_run++; if (got_q.size() !== 0) begin tests_failed++; $display("FAIL break_dv: got %0d expected 0", got_q.size()); end
    tests_run++; if (data !== 8'hA5) begin tests_failed++; $display("FAIL break_data_kept: got %h expected a5", data); end
    tests_run++; if (busy_seen !== 1'b0) begin tests_failed++; $display("FAIL break_rearm: got %b expected 0", busy_seen); end
    rx = 1'b1;
    repeat (20) @(negedge clk);
    clear_mon();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    tests_run++; if (got_q.size() !== 1 || data !== 8'h5A) begin tests_failed++; $display("FAIL break_recover: got %0d/%h expected 1/5a", got_q.size(), data); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    tests_run++; if (got_q.size() !== 2) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 2", got_q.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL b2b_data%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    end
    tests_run++; if (fe_cnt !== 0) begin tests_failed++; $display("FAIL b2b_fe: got %0d expected 0", fe_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    clear_mon();
    b = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    @(negedge clk);
    rx = b[4];
    repeat (200) @(negedge clk);
    tests_run++; if (bpssrt !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pre_bpssrt: got %b expected 1", bpssrt); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++; if (bpssrt !== 1'b0) begin tests_failed++; $display("FAIL rstmid_bpssrt: got %b expected 0", bpssrt); end
    tests_run++; if (state_dbg !== 3'd0) begin tests_failed++; $display("FAIL rstmid_state: got %0d expected 0", state_dbg); end
    repeat (BIT - 202) @(negedge clk);
    for (int i = 5; i < 8; i++) drive_bit(b[i]);
    drive_bit(1'b1);
    tests_run++; if (got_q.size() !== 0 || fe_cnt !== 0) begin tests_failed++; $display("FAIL rstmid_strobes: got dv %0d fe %0d expected 0 0", got_q.size(), fe_cnt); end
    clear_mon();
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    tests_run++; if (got_q.size() !== 1) begin tests_failed++; $display("FAIL rstmid_next_count: got %0d expected 1", got_q.size()); end
    tests_run++; if (data !== 8'h81) begin tests_failed++; $display("FAIL rstmid_next_data: got %h expected 81", data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_mon();
    parity_odd = 1'b0;
    send_frame(8'h55, 1'b1, 1'b1, 1'b1);
    tests_run++; if (pe_cnt !== 1) begin tests_failed++; $display("FAIL par_bad_pe: got %0d expected 1", pe_cnt); end
    tests_run++; if (got_q.size() !== 0) begin tests_failed++; $display("FAIL par_bad_dv: got %0d expected 0", got_q.size()); end
    clear_mon();
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    tests_run++; if (pe_cnt !== 0) begin tests_failed++; $display("FAIL par_ok_pe: got %0d expected 0", pe_cnt); end
    tests_run++; if (got_q.size() !== 1 || data !== 8'h55) begin tests_failed++; $display("FAIL par_ok_data: got %0d/%h expected 1/55", got_q.size(), data); end
  endtask
`endif

  initial begin
`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
`endif
    clear_mon();
    test_reset();
    test_single_frame();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
